// File: rtl/systolic_mm_engine.sv
// Output-stationary SIZE x SIZE systolic matrix multiply: C = A*B or C += A*B.
// Operands are captured on start, skewed into the array, and C is published on dout at done.
module systolic_pe #(
  parameter int DATAWIDTH = 16,
  parameter int ACCWIDTH  = 34
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [ACCWIDTH-1:0]  acc_nxt
);
  logic [ACCWIDTH-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + ACCWIDTH'(a) * ACCWIDTH'(b);
  end

  assign acc_nxt = acc_d;

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end
endmodule

module systolic_mm_engine #(
  parameter int SIZE      = 4,
  parameter int DATAWIDTH = 16,
  parameter int ACCWIDTH  = 2*DATAWIDTH+$clog2(SIZE),
  parameter int DIMW      = $clog2(SIZE+1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            acc_en,
  input  logic [DIMW-1:0]                 m_dim,
  input  logic [DIMW-1:0]                 k_dim,
  input  logic [DIMW-1:0]                 n_dim,
  input  logic [SIZE*SIZE*DATAWIDTH-1:0]  a_in,
  input  logic [SIZE*SIZE*DATAWIDTH-1:0]  b_in,
  output logic [SIZE*SIZE*ACCWIDTH-1:0]   dout,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);
  localparam int TW = $clog2(3*SIZE);
  localparam int IW = $clog2(SIZE);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  typedef logic [SIZE-1:0][SIZE-1:0][DATAWIDTH-1:0] op_t;

  state_t state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [DIMW-1:0] k_q, k_d;
  logic err_q, err_d, busy_q, busy_d, done_q, done_d;
  logic accept, finish, compute, legal;
  logic [TW-1:0] feed_end, drain_end;

  op_t a_in_v, b_in_v, a_op_q, a_op_d, b_op_q, b_op_d, pe_a, pe_b;
  logic [SIZE-1:0][SIZE-2:0][DATAWIDTH-1:0] a_sk_q, a_sk_d;
  logic [SIZE-2:0][SIZE-1:0][DATAWIDTH-1:0] b_sk_q, b_sk_d;
  logic [SIZE-1:0][DATAWIDTH-1:0] feed_a, feed_b;
  logic [SIZE-1:0][SIZE-1:0][ACCWIDTH-1:0] acc_nxt, dout_q, dout_d;

  assign a_in_v = a_in;
  assign b_in_v = b_in;
  assign legal  = (m_dim != '0) && (k_dim != '0) && (n_dim != '0) &&
                  (m_dim <= DIMW'(SIZE)) && (k_dim <= DIMW'(SIZE)) && (n_dim <= DIMW'(SIZE));
  assign compute   = (state_q == FEED) || (state_q == DRAIN);
  assign feed_end  = TW'(k_q) + TW'(SIZE-2);
  assign drain_end = TW'(k_q) + TW'(2*SIZE-3);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    k_d     = k_q;
    err_d   = err_q;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        err_d = !legal;
        if (legal) begin
          accept  = 1'b1;
          state_d = FEED;
          t_d     = '0;
          k_d     = k_dim;
        end else begin
          state_d = DONE;
        end
      end
      FEED: begin
        t_d = t_q + TW'(1);
        if (t_q == feed_end) state_d = DRAIN;
      end
      DRAIN: begin
        if (t_q == drain_end) begin
          finish  = 1'b1;
          state_d = DONE;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == FEED) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    dout_d = finish ? acc_nxt : dout_q;
  end

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_edge
    // Row gi of A and column gi of B share the same skew offset. When t < gi the
    // subtraction wraps to a value far above any legal k, so one compare suffices.
    logic [TW-1:0] kk;
    assign kk = t_q - TW'(gi);
    assign feed_a[gi] = (kk < TW'(k_q)) ? a_op_q[gi][IW'(kk)] : '0;
    assign feed_b[gi] = (kk < TW'(k_q)) ? b_op_q[IW'(kk)][gi] : '0;
  end

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_row
    for (genvar gj = 0; gj < SIZE; gj++) begin : g_col
      logic clr;

      if (gj == 0) begin : g_a_edge
        assign pe_a[gi][gj] = feed_a[gi];
      end else begin : g_a_hop
        assign pe_a[gi][gj] = a_sk_q[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign pe_b[gi][gj] = feed_b[gj];
      end else begin : g_b_hop
        assign pe_b[gi][gj] = b_sk_q[gi-1][gj];
      end
      if (gj < SIZE-1) begin : g_a_sk
        assign a_sk_d[gi][gj] = accept ? '0 : compute ? pe_a[gi][gj] : a_sk_q[gi][gj];
      end
      if (gi < SIZE-1) begin : g_b_sk
        assign b_sk_d[gi][gj] = accept ? '0 : compute ? pe_b[gi][gj] : b_sk_q[gi][gj];
      end

      // Zeroing out-of-range A rows / B columns keeps masked PEs at zero in both modes.
      assign a_op_d[gi][gj] = accept ? ((m_dim > DIMW'(gi)) ? a_in_v[gi][gj] : '0) : a_op_q[gi][gj];
      assign b_op_d[gi][gj] = accept ? ((n_dim > DIMW'(gj)) ? b_in_v[gi][gj] : '0) : b_op_q[gi][gj];
      assign clr = accept && (!acc_en || (m_dim <= DIMW'(gi)) || (n_dim <= DIMW'(gj)));

      systolic_pe #(.DATAWIDTH(DATAWIDTH), .ACCWIDTH(ACCWIDTH)) u_pe (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .en      (compute),
        .a       (pe_a[gi][gj]),
        .b       (pe_b[gi][gj]),
        .acc_nxt (acc_nxt[gi][gj])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      a_op_q  <= '0;
      b_op_q  <= '0;
      a_sk_q  <= '0;
      b_sk_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      k_q     <= k_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      a_op_q  <= a_op_d;
      b_op_q  <= b_op_d;
      a_sk_q  <= a_sk_d;
      b_sk_q  <= b_sk_d;
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
endmodule

// File: doc/systolic_mm_engine.md
# systolic_mm_engine

Parametrised SIZE×SIZE output-stationary systolic matrix-multiply engine, the next generation of the fixed 4×4/16-bit accelerator IP. It computes C = A·B, or C = C + A·B in accumulate mode, for runtime dimensions M×K by K×N with M, K, N ≤ SIZE. Operands are captured on a start handshake and fed into the array with internal row/column skew. Results are held on a flattened output bus until the next accepted start. It sits between the operand-staging logic and the result-writeback path of the accelerator.

## Interface
- SIZE, 4, array dimension (≥2)
- DATAWIDTH, 16, operand width (unsigned)
- ACCWIDTH, 2*DATAWIDTH+$clog2(SIZE), PE accumulator and result width
- DIMW, $clog2(SIZE+1), width of dimension inputs

Ports: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only while busy=0
- acc_en  in  1  sampled with start; 1 = add product to held C
- m_dim, k_dim, n_dim  in  DIMW  runtime dimensions, sampled with start
- a_in  in  SIZE*SIZE*DATAWIDTH  A(i,j) at bits [(i*SIZE+j)*DATAWIDTH +: DATAWIDTH]
- b_in  in  SIZE*SIZE*DATAWIDTH  B(i,j), same packing
- dout  out  SIZE*SIZE*ACCWIDTH  C(i,j) at bits [(i*SIZE+j)*ACCWIDTH +: ACCWIDTH]
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse at completion
- err  out  1  valid with done; 1 = illegal dimensions, no compute

## Operation
- FSM: IDLE → (start & legal dims) → FEED → DRAIN → DONE → IDLE. Illegal dims: IDLE → DONE directly.
- Accept: start=1 in IDLE. The engine latches a_in, b_in, dims and acc_en. A/B may change afterwards.
- Legal dims: 1 ≤ m,k,n ≤ SIZE. Any 0 or >SIZE is illegal: err=1, dout and PE state unchanged.
- Clear: on legal accept, acc_en=0 zeroes every PE accumulator; acc_en=1 keeps them.
- Feed: a step counter t runs 0..k+2·SIZE−3.
  - PE row i receives A(i, t−i) when 0 ≤ t−i < k, else 0.
  - PE column j receives B(t−j, j) when 0 ≤ t−j < k, else 0.
  - A propagates right and B propagates down, one register per PE hop.
- PE(i,j) adds a·b into its ACCWIDTH accumulator each cycle. Products are zero-extended; the sum wraps mod 2^ACCWIDTH.
- Masking: PE(i,j) with i≥m or j≥n is forced to 0 at accept, in both modes.
- dout mirrors the PE accumulators once DONE is reached. It holds stable while IDLE and only changes after the next legal accept.
- start while busy=1: ignored, no queueing.
- start asserted in the DONE cycle: ignored. start in the following IDLE cycle: accepted.

## Timing
- Reset values: busy=0, done=0, err=0, dout=0, all PE/skew registers 0, FSM=IDLE.
- Accept edge is E0. busy=1 from E0+1 through the cycle before done.
- Legal run: done=1 (err=0) in exactly one cycle, L = k + 2·SIZE − 1 cycles after the accept cycle.
  - Example: SIZE=4, k=4 → L=11.
- busy=0 in the done cycle.
- Illegal dims: done=1, err=1 in the cycle after accept. busy never rises.
- err holds its value until the next accept.
- Reset in any state: the next cycle is IDLE with all reset values. No done pulse is emitted for the aborted run.
- Back-to-back: minimum start-to-start spacing is L+1 cycles.

## Test plan
- SIZE=4, DATAWIDTH=16, m=k=n=4, acc_en=0.
  - Stimulus: A={5,2,6,1; 0,6,2,0; 3,8,1,4; 1,8,5,6}, B={7,5,8,0; 1,8,2,6; 9,4,3,8; 5,3,7,9}.
  - Expected: done 11 cycles after accept, err=0, dout={96,68,69,69; 24,56,18,52; 58,95,71,92; 90,107,81,142}.
- Accumulate: same operands again with acc_en=1 → dout doubles (C(0,0)=192, C(3,3)=284).
- Partial dims, same A/B, m=2, k=3, n=2, acc_en=0.
  - done after 10 cycles.
  - C(0,0)=91, C(0,1)=65, C(1,0)=24, C(1,1)=56; all other entries 0.
- Width/overflow: all A, B = 0xFFFF, 4×4 → every C = 17179344900, with no wrap at ACCWIDTH=34.
- Illegal dims (k=0, then n=5):
  - done=1, err=1 one cycle after accept; busy stays 0; dout unchanged.
  - A subsequent legal run clears err.
- Control:
  - start pulsed during busy → ignored; the run completes with correct C.
  - reset asserted mid-FEED → next cycle busy=0, dout=0, no done.
  - start asserted during the done cycle → ignored.
